// File: rtl/enc74148_sync.sv
// Clocked 74148-style 8-to-3 priority encoder with input synchronisers,
// debounce of the winning code and a hold/acknowledge handshake.
module enc74148_sync #(
   parameter int unsigned DEB_CYCLES = 4,
   parameter int unsigned CNT_W      = 8
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [7:0] in_bar,
   input  logic       ei_bar,
   input  logic       ack,
   output logic       a,
   output logic       b,
   output logic       c,
   output logic       gs_bar,
   output logic       eo_bar,
   output logic       valid
);

   typedef enum logic [1:0] {IDLE, DEBOUNCE, HOLD, RELEASE} state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

   state_t           state;
   logic [7:0]       in_meta;
   logic [7:0]       in_s;
   logic             ei_meta;
   logic             ei_s;
   logic [2:0]       cand;
   logic [2:0]       code;
   logic [CNT_W-1:0] cnt;
   logic [7:0]       req;
   logic             any;
   logic [2:0]       win;

   // Two-flop synchronisers, preset to the idle (all released, disabled) level.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_meta <= 8'hFF;
         in_s    <= 8'hFF;
         ei_meta <= 1'b1;
         ei_s    <= 1'b1;
      end else begin
         in_meta <= in_bar;
         in_s    <= in_meta;
         ei_meta <= ei_bar;
         ei_s    <= ei_meta;
      end
   end

   assign req = ~in_s;
   assign any = |req;

   always_comb begin
      win = 3'd0;
      for (int i = 0; i < 8; i++) begin
         if (req[i]) begin
            win = 3'(i);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         eo_bar <= 1'b1;
      end else begin
         eo_bar <= ~(!ei_s && !any);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         cand   <= 3'd0;
         cnt    <= '0;
         code   <= 3'd0;
         gs_bar <= 1'b1;
         valid  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!ei_s && any) begin
                  state <= DEBOUNCE;
                  cand  <= win;
                  cnt   <= '0;
               end
            end
            DEBOUNCE: begin
               if (ei_s || !any) begin
                  state <= IDLE;
               end else if (win != cand) begin
                  cand <= win;
                  cnt  <= '0;
               end else if (cnt == CNT_LAST) begin
                  state  <= HOLD;
                  code   <= cand;
                  gs_bar <= 1'b0;
                  valid  <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            HOLD: begin
               // A disable takes precedence over a coincident acknowledge.
               if (ei_s) begin
                  state  <= IDLE;
                  valid  <= 1'b0;
                  gs_bar <= 1'b1;
                  code   <= 3'd0;
               end else if (ack) begin
                  state <= RELEASE;
                  valid <= 1'b0;
               end
            end
            RELEASE: begin
               if (ei_s || !any) begin
                  state  <= IDLE;
                  gs_bar <= 1'b1;
                  code   <= 3'd0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign {a, b, c} = code;

endmodule

// File: doc/enc74148_sync.md
Name: enc74148_sync

Overview:
- Clocked 8-to-3 priority encoder with 74148 pin semantics: active-low request lines, enable-in, group-select and enable-out.
- Performs the inverse of the 3-to-8 active-low decoder. The {a,b,c} code it produces, fed back into that decoder, drives low exactly the winning request line's index.
- Adds input synchronisation, debounce and a hold/acknowledge handshake. This lets it sit between asynchronous switch/keypad lines and clocked logic.

Parameters:
- DEB_CYCLES, 4, consecutive stable cycles a winning code must persist before it is latched. Legal range 1..255.
- CNT_W, 8, width of the debounce counter. Must satisfy 2^CNT_W > DEB_CYCLES.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_bar  input  8  active-low request lines; bit 7 is highest priority.
- ei_bar  input  1  active-low enable-in.
- ack  input  1  consumer acknowledge; single-cycle pulse.
- a  output  1  code MSB. Registered; {a,b,c} equals the winning index.
- b  output  1  code middle bit.
- c  output  1  code LSB.
- gs_bar  output  1  active-low group select; low while a code is held.
- eo_bar  output  1  active-low enable-out; low when enabled and no request is present.
- valid  output  1  high while the latched code awaits ack.

Behaviour:
- Reset (async, rst_n=0): state IDLE; {a,b,c}=000; gs_bar=1; eo_bar=1; valid=0; counter=0; both synchroniser stages preset to all ones (in_bar and ei_bar).
- Synchroniser: in_bar and ei_bar each pass through 2 flops, giving in_s and ei_s. All decisions use the synchronised values only.
- Priority: req=~in_s. win = highest set index of req; any = |req. With several lines low, the highest index wins; lower indices are ignored.
- eo_bar: registered each cycle as ~(ei_s==0 && any==0). It is independent of state.
- IDLE: if ei_s==0 and any, go to DEBOUNCE with cand<=win and cnt<=0. Otherwise stay.
- DEBOUNCE:
  - ei_s==1 or !any: go to IDLE.
  - win!=cand: cand<=win, cnt<=0; stay.
  - win==cand and cnt==DEB_CYCLES-1: go to HOLD with {a,b,c}<=cand, gs_bar<=0, valid<=1.
  - Otherwise cnt<=cnt+1.
  - The counter saturates by construction and never wraps.
- HOLD: outputs frozen regardless of input changes.
  - ack=1: go to RELEASE with valid<=0. gs_bar and {a,b,c} keep their values.
  - ei_s==1: go to IDLE with valid<=0, gs_bar<=1, {a,b,c}<=000.
  - ack and ei_s==1 in the same cycle: the disable wins and the IDLE path is taken.
  - ack is sampled only while in HOLD. ack is ignored in IDLE, DEBOUNCE and RELEASE, including the cycle of entry into HOLD.
- RELEASE: waits for all requests released, then goes to IDLE with gs_bar<=1 and {a,b,c}<=000. This prevents auto-repeat of one held key.
  - Release condition: !any for 1 cycle.
  - ei_s==1 in RELEASE also goes to IDLE with the same output clearing.
- Latency: count the first rising edge that samples an in_bar change as edge 1. IDLE→DEBOUNCE occurs at edge 3. valid, gs_bar and the code update at edge 3+DEB_CYCLES if the input is stable throughout.
- Reset asserted mid-operation: immediate return to the reset values; no partial code is retained.

Test Plan:
- Reset, DEB_CYCLES=4, in_bar=FF, ei_bar=0: eo_bar=0 after 3 edges; valid=0, gs_bar=1, {a,b,c}=000.
- Drive in_bar=F7 (line 3) and hold: valid=1, gs_bar=0, {a,b,c}=011 exactly at edge 7. One-cycle ack → valid=0 next edge. Release in_bar=FF → gs_bar=1, code=000, state IDLE.
- in_bar=5E (lines 7, 5, 0 low): code=111 latched. Decoder loopback with e1_bar=0, e2_bar=0, e3=1 gives decoder out=7F.
- Bounce: alternate in_bar between FB and FF every cycle for 10 cycles → valid stays 0. Then hold FB for 4 stable cycles after sync → code=010.
- Code change during debounce: F7 for 2 cycles then 7F → counter restarts. code=111 latched 4 cycles after the change; code 011 is never latched.
- In HOLD, assert ack and ei_bar=1 on the same synchronised cycle → IDLE, valid=0, gs_bar=1, code=000. Separately, pulse rst_n low mid-DEBOUNCE → all outputs return to reset values asynchronously.
